// File: rtl/room_temp_model.sv
// Closed-loop room plant: integrates heater/cooler commands into a saturating
// 5-bit temperature, drifting toward ambient when neither is active.
module room_temp_model #(
    parameter int TEMP_INIT    = 18,
    parameter int AMBIENT      = 22,
    parameter int TEMP_MIN     = 5,
    parameter int TEMP_MAX     = 30,
    parameter int HEAT_PERIOD  = 4,
    parameter int COOL_PERIOD  = 4,
    parameter int DRIFT_PERIOD = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       heating_i,
    input  logic       cooling_i,
    input  logic       load_en_i,
    input  logic [4:0] load_value_i,
    output logic [4:0] temperature_o,
    output logic       temp_step_o,
    output logic       fault_o
);

    localparam int MAX_P12 = (HEAT_PERIOD > COOL_PERIOD) ? HEAT_PERIOD : COOL_PERIOD;
    localparam int MAX_P   = (MAX_P12 > DRIFT_PERIOD) ? MAX_P12 : DRIFT_PERIOD;
    localparam int CNT_W   = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [4:0] T_INIT = 5'(TEMP_INIT);
    localparam logic [4:0] T_AMB  = 5'(AMBIENT);
    localparam logic [4:0] T_MIN  = 5'(TEMP_MIN);
    localparam logic [4:0] T_MAX  = 5'(TEMP_MAX);

    localparam logic [CNT_W-1:0] HEAT_LAST  = CNT_W'(HEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOL_PERIOD - 1);
    localparam logic [CNT_W-1:0] DRIFT_LAST = CNT_W'(DRIFT_PERIOD - 1);

    // Encoding matches {cooling, heating} so the requested mode is a direct cast.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        HEAT  = 2'b01,
        COOL  = 2'b10,
        FAULT = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       temp_q, temp_d;
    logic             step_q, step_d;
    logic             fault_q, fault_d;

    state_t           reqState;
    logic [CNT_W-1:0] lastCnt;
    logic [4:0]       loadClamped;
    logic [4:0]       stepTemp;

    always_comb begin
        reqState = state_t'({cooling_i, heating_i});

        lastCnt = '0;
        case (state_q)
            HEAT:    lastCnt = HEAT_LAST;
            COOL:    lastCnt = COOL_LAST;
            IDLE:    lastCnt = DRIFT_LAST;
            default: lastCnt = '0;
        endcase

        if (load_value_i < T_MIN) begin
            loadClamped = T_MIN;
        end else if (load_value_i > T_MAX) begin
            loadClamped = T_MAX;
        end else begin
            loadClamped = load_value_i;
        end

        // Candidate temperature if this edge completes a prescaler period.
        stepTemp = temp_q;
        case (state_q)
            HEAT: begin
                if (temp_q < T_MAX) stepTemp = temp_q + 5'd1;
            end
            COOL: begin
                if (temp_q > T_MIN) stepTemp = temp_q - 5'd1;
            end
            IDLE: begin
                if (temp_q < T_AMB && temp_q < T_MAX) begin
                    stepTemp = temp_q + 5'd1;
                end else if (temp_q > T_AMB && temp_q > T_MIN) begin
                    stepTemp = temp_q - 5'd1;
                end
            end
            default: stepTemp = temp_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        temp_d  = temp_q;
        step_d  = 1'b0;

        if (load_en_i) begin
            temp_d  = loadClamped;
            cnt_d   = '0;
            state_d = reqState;
            step_d  = (loadClamped != temp_q);
        end else if (reqState != state_q) begin
            // Any mode change discards the partial prescaler count.
            state_d = reqState;
            cnt_d   = '0;
        end else if (state_q == FAULT) begin
            cnt_d = cnt_q;
        end else if (cnt_q == lastCnt) begin
            cnt_d  = '0;
            temp_d = stepTemp;
            step_d = (stepTemp != temp_q);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        fault_d = (state_d == FAULT);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            temp_q  <= T_INIT;
            step_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            temp_q  <= temp_d;
            step_q  <= step_d;
            fault_q <= fault_d;
        end
    end

    assign temperature_o = temp_q;
    assign temp_step_o   = step_q;
    assign fault_o       = fault_q;

endmodule

// File: tb/tb_room_temp_model.sv
// Directed bench for the room temperature plant, including a small bang-bang
// controller loop closed around the model.
module tb_room_temp_model;

    logic       clk;
    logic       rst;
    logic       heating;
    logic       cooling;
    logic       loadEn;
    logic [4:0] loadValue;
    logic [4:0] temperature;
    logic       tempStep;
    logic       fault;

    int total = 0;
    int bad   = 0;

    room_temp_model dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .heating_i    (heating),
        .cooling_i    (cooling),
        .load_en_i    (loadEn),
        .load_value_i (loadValue),
        .temperature_o(temperature),
        .temp_step_o  (tempStep),
        .fault_o      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            tick();
            if (tempStep === 1'b1) pulses++;
        end
    endtask

    task automatic loadTemp(input logic [4:0] v);
        loadEn    = 1'b1;
        loadValue = v;
        tick();
        loadEn    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; heating = 1'b0; cooling = 1'b0; loadEn = 1'b0; loadValue = 5'd0;
        tick();
        tick();
        total++; if (temperature !== 5'd18) begin bad++; $display("[TB] FAIL reset_temp got=%0d exp=18", temperature); end
        total++; if (tempStep !== 1'b0) begin bad++; $display("[TB] FAIL reset_step got=%b exp=0", tempStep); end
        total++; if (fault !== 1'b0) begin bad++; $display("[TB] FAIL reset_fault got=%b exp=0", fault); end
    endtask

    task automatic test_heat_ramp();
        int p;
        int pulses;
        rst = 1'b0;
        heating = 1'b1;
        tick();
        pulses = (tempStep === 1'b1) ? 1 : 0;
        total++; if (temperature !== 5'd18) begin bad++; $display("[TB] FAIL heat_entry got=%0d exp=18", temperature); end
        ticks(3, p); pulses += p;
        total++; if (temperature !== 5'd18) begin bad++; $display("[TB] FAIL heat_pre_step got=%0d exp=18", temperature); end
        tick();
        if (tempStep === 1'b1) pulses++;
        total++; if (temperature !== 5'd19 || tempStep !== 1'b1) begin bad++; $display("[TB] FAIL heat_first_step got=%0d/%b exp=19/1", temperature, tempStep); end
        ticks(36, p); pulses += p;
        total++; if (temperature !== 5'd28) begin bad++; $display("[TB] FAIL heat_final got=%0d exp=28", temperature); end
        total++; if (pulses != 10) begin bad++; $display("[TB] FAIL heat_pulses got=%0d exp=10", pulses); end
    endtask

    task automatic test_saturate();
        int p;
        loadTemp(5'd29);
        total++; if (temperature !== 5'd29 || tempStep !== 1'b1) begin bad++; $display("[TB] FAIL sat_load got=%0d/%b exp=29/1", temperature, tempStep); end
        ticks(3, p);
        total++; if (temperature !== 5'd29 || p != 0) begin bad++; $display("[TB] FAIL sat_pre got=%0d/%0d exp=29/0", temperature, p); end
        tick();
        total++; if (temperature !== 5'd30 || tempStep !== 1'b1) begin bad++; $display("[TB] FAIL sat_step got=%0d/%b exp=30/1", temperature, tempStep); end
        ticks(8, p);
        total++; if (temperature !== 5'd30 || p != 0) begin bad++; $display("[TB] FAIL sat_hold got=%0d/%0d exp=30/0", temperature, p); end
    endtask

    task automatic test_load_clamp();
        loadTemp(5'd31);
        total++; if (temperature !== 5'd30 || tempStep !== 1'b0) begin bad++; $display("[TB] FAIL clamp_high got=%0d/%b exp=30/0", temperature, tempStep); end
        loadTemp(5'd0);
        total++; if (temperature !== 5'd5 || tempStep !== 1'b1) begin bad++; $display("[TB] FAIL clamp_low got=%0d/%b exp=5/1", temperature, tempStep); end
    endtask

    task automatic test_cool_restart();
        int p;
        heating = 1'b0;
        cooling = 1'b1;
        loadTemp(5'd25);
        tick();
        tick();
        cooling = 1'b0;
        tick();
        cooling = 1'b1;
        tick();
        ticks(3, p);
        total++; if (temperature !== 5'd25 || p != 0) begin bad++; $display("[TB] FAIL cool_restart_hold got=%0d/%0d exp=25/0", temperature, p); end
        tick();
        total++; if (temperature !== 5'd24 || tempStep !== 1'b1) begin bad++; $display("[TB] FAIL cool_restart_step got=%0d/%b exp=24/1", temperature, tempStep); end
    endtask

    task automatic test_drift();
        int p;
        cooling = 1'b0;
        loadTemp(5'd15);
        ticks(15, p);
        total++; if (temperature !== 5'd15) begin bad++; $display("[TB] FAIL drift_pre got=%0d exp=15", temperature); end
        tick();
        total++; if (temperature !== 5'd16) begin bad++; $display("[TB] FAIL drift_first got=%0d exp=16", temperature); end
        ticks(96, p);
        total++; if (temperature !== 5'd22 || p != 6) begin bad++; $display("[TB] FAIL drift_up got=%0d/%0d exp=22/6", temperature, p); end
        ticks(32, p);
        total++; if (temperature !== 5'd22 || p != 0) begin bad++; $display("[TB] FAIL drift_hold got=%0d/%0d exp=22/0", temperature, p); end
        loadTemp(5'd26);
        ticks(16, p);
        total++; if (temperature !== 5'd25) begin bad++; $display("[TB] FAIL drift_down_first got=%0d exp=25", temperature); end
        ticks(48, p);
        total++; if (temperature !== 5'd22 || p != 3) begin bad++; $display("[TB] FAIL drift_down got=%0d/%0d exp=22/3", temperature, p); end
    endtask

    task automatic test_fault();
        int p;
        heating = 1'b1;
        cooling = 1'b1;
        tick();
        total++; if (fault !== 1'b1 || temperature !== 5'd22) begin bad++; $display("[TB] FAIL fault_entry got=%b/%0d exp=1/22", fault, temperature); end
        ticks(9, p);
        total++; if (fault !== 1'b1 || temperature !== 5'd22 || p != 0) begin bad++; $display("[TB] FAIL fault_hold got=%b/%0d/%0d exp=1/22/0", fault, temperature, p); end
        heating = 1'b0;
        cooling = 1'b0;
        tick();
        total++; if (fault !== 1'b0) begin bad++; $display("[TB] FAIL fault_exit got=%b exp=0", fault); end
    endtask

    task automatic test_reset_midrun();
        int p;
        heating = 1'b1;
        loadTemp(5'd15);
        tick();
        tick();
        rst       = 1'b1;
        loadEn    = 1'b1;
        loadValue = 5'd9;
        tick();
        total++; if (temperature !== 5'd18 || fault !== 1'b0 || tempStep !== 1'b0) begin bad++; $display("[TB] FAIL midrun_reset got=%0d/%b/%b exp=18/0/0", temperature, fault, tempStep); end
        rst     = 1'b0;
        loadEn  = 1'b0;
        heating = 1'b0;
        ticks(15, p);
        total++; if (temperature !== 5'd18) begin bad++; $display("[TB] FAIL midrun_cnt_clear got=%0d exp=18", temperature); end
        tick();
        total++; if (temperature !== 5'd19) begin bad++; $display("[TB] FAIL midrun_first_drift got=%0d exp=19", temperature); end
    endtask

    task automatic test_loop();
        int outOfRange;
        heating = 1'b0;
        cooling = 1'b0;
        loadTemp(5'd28);
        repeat (200) begin
            heating = (temperature < 5'd18);
            cooling = (temperature > 5'd22);
            tick();
        end
        total++; if (temperature < 5'd18 || temperature > 5'd22) begin bad++; $display("[TB] FAIL loop_settle got=%0d exp=18..22", temperature); end
        outOfRange = 0;
        repeat (100) begin
            heating = (temperature < 5'd18);
            cooling = (temperature > 5'd22);
            tick();
            if (temperature < 5'd18 || temperature > 5'd22) outOfRange++;
        end
        total++; if (outOfRange != 0) begin bad++; $display("[TB] FAIL loop_stay got=%0d exp=0", outOfRange); end
    endtask

    initial begin
        test_reset();
        test_heat_ramp();
        test_saturate();
        test_load_clamp();
        test_cool_restart();
        test_drift();
        test_fault();
        test_reset_midrun();
        test_loop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
